// File: rtl/flow_match_pkg.sv
//-----------------------------------------------------------------------------
// flow_match_pkg
// Shared constants, the flow-table entry layout and the saturating adder
// used by flow_tcam and flow_match_engine.
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

package flow_match_pkg;

  localparam int C_KEY_WIDTH      = 32;
  localparam int C_FT_ADDR_WIDTH  = 4;
  localparam int C_FT_DEPTH       = 16;
  localparam int C_NUM_ACTIONS    = 4;
  localparam int C_THREAD_BITS    = 2;
  localparam int C_CNT_WIDTH      = 32;
  localparam int C_LEN_WIDTH      = 16;
  localparam int C_DEFAULT_ACTION = 0;

  // Entry layout at the default geometry; flow_tcam declares the same
  // layout sized by its own parameters.
  typedef struct packed {
    logic [C_KEY_WIDTH-1:0]   key;
    logic [C_KEY_WIDTH-1:0]   mask;
    logic [C_NUM_ACTIONS-1:0] action;
    logic                     en;
  } flow_entry_t;

  // a + b clamped to (2**width)-1. Operands are carried at 64 bits so one
  // function serves every counter width up to 64.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/flow_tcam.sv
//-----------------------------------------------------------------------------
// flow_tcam
// Ternary entry storage with a single config write port, a combinational
// match vector for the incoming key, and an action read port.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_cfg_*                entry write (out-of-range addresses ignored)
//   i_lkp_key / o_match    key under lookup / per-entry hit vector
//   i_act_addr / o_act     action read port
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module flow_tcam
  import flow_match_pkg::*;
#(
  parameter int KEY_WIDTH     = C_KEY_WIDTH,
  parameter int FT_ADDR_WIDTH = C_FT_ADDR_WIDTH,
  parameter int FT_DEPTH      = C_FT_DEPTH,
  parameter int NUM_ACTIONS   = C_NUM_ACTIONS
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cfg_we,
  input  logic [FT_ADDR_WIDTH-1:0] i_cfg_addr,
  input  logic [KEY_WIDTH-1:0]     i_cfg_key,
  input  logic [KEY_WIDTH-1:0]     i_cfg_mask,
  input  logic [NUM_ACTIONS-1:0]   i_cfg_action,
  input  logic                     i_cfg_entry_en,
  input  logic [KEY_WIDTH-1:0]     i_lkp_key,
  output logic [FT_DEPTH-1:0]      o_match,
  input  logic [FT_ADDR_WIDTH-1:0] i_act_addr,
  output logic [NUM_ACTIONS-1:0]   o_act
);

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [KEY_WIDTH-1:0]   mask;
    logic [NUM_ACTIONS-1:0] action;
    logic                   en;
  } entry_t;

  entry_t r_entry [FT_DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FT_DEPTH; i++) r_entry[i] <= '0;
    end else begin
      for (int i = 0; i < FT_DEPTH; i++) begin
        if (i_cfg_we && (i_cfg_addr == FT_ADDR_WIDTH'(i))) begin
          r_entry[i] <= '{key: i_cfg_key, mask: i_cfg_mask,
                          action: i_cfg_action, en: i_cfg_entry_en};
        end
      end
    end
  end

  always_comb begin
    o_match = '0;
    for (int i = 0; i < FT_DEPTH; i++) begin
      o_match[i] = r_entry[i].en &&
                   (((i_lkp_key ^ r_entry[i].key) & r_entry[i].mask) == '0);
    end
  end

  always_comb begin
    o_act = '0;
    for (int i = 0; i < FT_DEPTH; i++) begin
      if (i_act_addr == FT_ADDR_WIDTH'(i)) o_act = r_entry[i].action;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flow_match_engine.sv
//-----------------------------------------------------------------------------
// flow_match_engine
// Two-stage ternary flow lookup (lowest-index hit wins) with valid/ready
// request and response handshakes and saturating per-entry counters that
// support clear-on-read.
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_req_* / o_req_ready             lookup request
//   o_rsp_* / i_rsp_ready             lookup result
//   i_cfg_*                           table write (blocks requests that cycle)
//   i_cnt_rd_* / i_cnt_clear          counter read, optional clear
//   o_cnt_rd_valid, o_cnt_*_out       counter read data, one cycle later
// Build option: define FLOW_BYTE_COUNT_EN to implement byte counters;
// otherwise o_cnt_byte_out is 0 and i_req_len is ignored.
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module flow_match_engine
  import flow_match_pkg::*;
#(
  parameter int KEY_WIDTH      = C_KEY_WIDTH,
  parameter int FT_ADDR_WIDTH  = C_FT_ADDR_WIDTH,
  parameter int FT_DEPTH       = C_FT_DEPTH,
  parameter int NUM_ACTIONS    = C_NUM_ACTIONS,
  parameter int THREAD_BITS    = C_THREAD_BITS,
  parameter int CNT_WIDTH      = C_CNT_WIDTH,
  parameter int LEN_WIDTH      = C_LEN_WIDTH,
  parameter int DEFAULT_ACTION = C_DEFAULT_ACTION
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [KEY_WIDTH-1:0]     i_req_key,
  input  logic [THREAD_BITS-1:0]   i_req_thread,
  input  logic [LEN_WIDTH-1:0]     i_req_len,
  input  logic                     i_req_count,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic                     o_rsp_hit,
  output logic [FT_ADDR_WIDTH-1:0] o_rsp_addr,
  output logic [NUM_ACTIONS-1:0]   o_rsp_action,
  output logic [THREAD_BITS-1:0]   o_rsp_thread,
  input  logic                     i_cfg_we,
  input  logic [FT_ADDR_WIDTH-1:0] i_cfg_addr,
  input  logic [KEY_WIDTH-1:0]     i_cfg_key,
  input  logic [KEY_WIDTH-1:0]     i_cfg_mask,
  input  logic [NUM_ACTIONS-1:0]   i_cfg_action,
  input  logic                     i_cfg_entry_en,
  input  logic                     i_cnt_rd_en,
  input  logic [FT_ADDR_WIDTH-1:0] i_cnt_rd_addr,
  input  logic                     i_cnt_clear,
  output logic                     o_cnt_rd_valid,
  output logic [CNT_WIDTH-1:0]     o_cnt_pkt_out,
  output logic [CNT_WIDTH-1:0]     o_cnt_byte_out
);

  logic [FT_DEPTH-1:0]      w_match;
  logic [NUM_ACTIONS-1:0]   w_act;
  logic                     w_enc_hit;
  logic [FT_ADDR_WIDTH-1:0] w_enc_addr;
  logic                     w_s2_stall;
  logic                     w_s1_adv;
  logic                     w_accept;
  logic                     w_upd;
  logic [FT_DEPTH-1:0]      w_upd_vec;
  logic [FT_DEPTH-1:0]      w_clr_vec;
  logic [CNT_WIDTH-1:0]     w_rd_pkt;

  // Holds req_ready low until the first edge after reset is released.
  logic                     r_live;

  logic                     r_s1_valid;
  logic [FT_DEPTH-1:0]      r_s1_match;
  logic [THREAD_BITS-1:0]   r_s1_thread;
  logic                     r_s1_count;

  logic                     r_s2_valid;
  logic                     r_s2_hit;
  logic [FT_ADDR_WIDTH-1:0] r_s2_addr;
  logic [NUM_ACTIONS-1:0]   r_s2_action;
  logic [THREAD_BITS-1:0]   r_s2_thread;

  logic [CNT_WIDTH-1:0]     r_pkt [FT_DEPTH];
  logic                     r_rd_valid;
  logic [CNT_WIDTH-1:0]     r_rd_pkt;

  flow_tcam #(
    .KEY_WIDTH     (KEY_WIDTH),
    .FT_ADDR_WIDTH (FT_ADDR_WIDTH),
    .FT_DEPTH      (FT_DEPTH),
    .NUM_ACTIONS   (NUM_ACTIONS)
  ) u_tcam (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_addr     (i_cfg_addr),
    .i_cfg_key      (i_cfg_key),
    .i_cfg_mask     (i_cfg_mask),
    .i_cfg_action   (i_cfg_action),
    .i_cfg_entry_en (i_cfg_entry_en),
    .i_lkp_key      (i_req_key),
    .o_match        (w_match),
    .i_act_addr     (w_enc_addr),
    .o_act          (w_act)
  );

  // Handshake
  assign w_s2_stall  = r_s2_valid && !i_rsp_ready;
  assign w_s1_adv    = r_s1_valid && !w_s2_stall;
  assign o_req_ready = r_live && !i_cfg_we && !(r_s1_valid && w_s2_stall);
  assign w_accept    = i_req_valid && o_req_ready;

  // Priority encoder: scanning downwards lets the lowest index win.
  always_comb begin
    w_enc_hit  = 1'b0;
    w_enc_addr = '0;
    for (int i = FT_DEPTH - 1; i >= 0; i--) begin
      if (r_s1_match[i]) begin
        w_enc_hit  = 1'b1;
        w_enc_addr = FT_ADDR_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  // S1: capture match vector and request side-band
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_match  <= '0;
      r_s1_thread <= '0;
      r_s1_count  <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_match  <= w_match;
      r_s1_thread <= i_req_thread;
      r_s1_count  <= i_req_count;
    end else if (w_s1_adv) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // S2: response holding register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_hit    <= 1'b0;
      r_s2_addr   <= '0;
      r_s2_action <= '0;
      r_s2_thread <= '0;
    end else if (!w_s2_stall) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_hit    <= w_enc_hit;
        r_s2_addr   <= w_enc_addr;
        r_s2_action <= w_enc_hit ? w_act : NUM_ACTIONS'(DEFAULT_ACTION);
        r_s2_thread <= r_s1_thread;
      end
    end
  end

  assign o_rsp_valid  = r_s2_valid;
  assign o_rsp_hit    = r_s2_hit;
  assign o_rsp_addr   = r_s2_addr;
  assign o_rsp_action = r_s2_action;
  assign o_rsp_thread = r_s2_thread;

  // Counter events: an update lands on the S1->S2 transfer of a counted hit.
  assign w_upd = w_s1_adv && w_enc_hit && r_s1_count;

  always_comb begin
    w_upd_vec = '0;
    w_clr_vec = '0;
    w_rd_pkt  = '0;
    for (int i = 0; i < FT_DEPTH; i++) begin
      w_upd_vec[i] = w_upd && (w_enc_addr == FT_ADDR_WIDTH'(i));
      w_clr_vec[i] = i_cnt_rd_en && i_cnt_clear &&
                     (i_cnt_rd_addr == FT_ADDR_WIDTH'(i));
      if (i_cnt_rd_addr == FT_ADDR_WIDTH'(i)) w_rd_pkt = r_pkt[i];
    end
  end

  // A clear colliding with an update leaves only that update, so the read
  // returns the old value and no event is lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FT_DEPTH; i++) r_pkt[i] <= '0;
    end else begin
      for (int i = 0; i < FT_DEPTH; i++) begin
        if (w_upd_vec[i]) begin
          r_pkt[i] <= w_clr_vec[i] ? CNT_WIDTH'(1)
                    : CNT_WIDTH'(sat_add(64'(r_pkt[i]), 64'd1, CNT_WIDTH));
        end else if (w_clr_vec[i]) begin
          r_pkt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_pkt   <= '0;
    end else begin
      r_rd_valid <= i_cnt_rd_en;
      if (i_cnt_rd_en) r_rd_pkt <= w_rd_pkt;
    end
  end

  assign o_cnt_rd_valid = r_rd_valid;
  assign o_cnt_pkt_out  = r_rd_pkt;

`ifdef FLOW_BYTE_COUNT_EN
  logic [LEN_WIDTH-1:0] r_s1_len;
  logic [CNT_WIDTH-1:0] r_byte [FT_DEPTH];
  logic [CNT_WIDTH-1:0] w_rd_byte;
  logic [CNT_WIDTH-1:0] r_rd_byte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_s1_len <= '0;
    else if (w_accept) r_s1_len <= i_req_len;
  end

  always_comb begin
    w_rd_byte = '0;
    for (int i = 0; i < FT_DEPTH; i++) begin
      if (i_cnt_rd_addr == FT_ADDR_WIDTH'(i)) w_rd_byte = r_byte[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FT_DEPTH; i++) r_byte[i] <= '0;
      r_rd_byte <= '0;
    end else begin
      for (int i = 0; i < FT_DEPTH; i++) begin
        if (w_upd_vec[i]) begin
          r_byte[i] <= CNT_WIDTH'(sat_add(w_clr_vec[i] ? 64'd0 : 64'(r_byte[i]),
                                          64'(r_s1_len), CNT_WIDTH));
        end else if (w_clr_vec[i]) begin
          r_byte[i] <= '0;
        end
      end
      if (i_cnt_rd_en) r_rd_byte <= w_rd_byte;
    end
  end

  assign o_cnt_byte_out = r_rd_byte;
`else
  logic w_unused_len;
  assign w_unused_len   = ^i_req_len;
  assign o_cnt_byte_out = '0;
`endif

endmodule

`default_nettype wire
